decode_stage: RTL and testbench

Instruction decode stage sitting directly upstream of the 32x32 register file. It accepts fetched instructions over a valid/ready handshake and drives the register-file read addresses. It captures operands into an ID/EX pipeline register toward execute. A write-pending scoreboard stalls issue on read-after-write hazards until writeback retires the producing write.

---
 rtl/decode_stage.sv | 177 +++++++++++++++++
 tb/tb_decode_stage.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// Decode stage: decodes MIPS instructions, reads the register file and loads the
// ID/EX register, stalling on read-after-write hazards tracked by a write-pending scoreboard.
module decode_stage #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic                    elk,
  input  logic                    nrst,
  input  logic                    if_valid,
  input  logic [31:0]             if_instr,
  input  logic [31:0]             if_pc,
  output logic                    if_ready,
  output logic [$clog2(NREG)-1:0] rd_addrA,
  output logic [$clog2(NREG)-1:0] rd_addrB,
  input  logic [XLEN-1:0]         rd_dataA,
  input  logic [XLEN-1:0]         rd_dataB,
  output logic                    ex_valid,
  input  logic                    ex_ready,
  output logic [3:0]              ex_op,
  output logic [XLEN-1:0]         ex_opA,
  output logic [XLEN-1:0]         ex_opB,
  output logic [XLEN-1:0]         ex_imm,
  output logic                    ex_use_imm,
  output logic [$clog2(NREG)-1:0] ex_dest,
  output logic                    ex_we,
  output logic [31:0]             ex_pc,
  input  logic                    wb_en,
  input  logic [$clog2(NREG)-1:0] wb_addr,
  input  logic                    flush,
  output logic                    err
);
  localparam int RW = $clog2(NREG);

  typedef enum logic [3:0] {
    OP_NOP = 4'd0, OP_ADD = 4'd1, OP_SUB = 4'd2, OP_AND = 4'd3, OP_OR = 4'd4,
    OP_SLT = 4'd5, OP_LW = 4'd6, OP_SW = 4'd7, OP_BEQ = 4'd8
  } op_t;

  logic [5:0]    opcode, funct;
  logic [RW-1:0] rs, rt, rd;
  assign opcode = if_instr[31:26];
  assign rs     = if_instr[25:21];
  assign rt     = if_instr[20:16];
  assign rd     = if_instr[15:11];
  assign funct  = if_instr[5:0];

  assign rd_addrA = rs;
  assign rd_addrB = rt;

  op_t           dec_op;
  logic          dec_use_imm, dec_we_raw, dec_we, dec_bad, use_rs, use_rt;
  logic [RW-1:0] dec_dest;
  logic [XLEN-1:0] dec_imm;

  always_comb begin
    dec_op      = OP_NOP;
    dec_use_imm = 1'b0;
    dec_we_raw  = 1'b0;
    dec_dest    = '0;
    use_rs      = 1'b0;
    use_rt      = 1'b0;
    dec_bad     = 1'b0;
    case (opcode)
      6'h00: begin
        use_rs     = 1'b1;
        use_rt     = 1'b1;
        dec_dest   = rd;
        dec_we_raw = 1'b1;
        case (funct)
          6'h20: dec_op = OP_ADD;
          6'h22: dec_op = OP_SUB;
          6'h24: dec_op = OP_AND;
          6'h25: dec_op = OP_OR;
          6'h2A: dec_op = OP_SLT;
          default: begin
            use_rs     = 1'b0;
            use_rt     = 1'b0;
            dec_dest   = '0;
            dec_we_raw = 1'b0;
            dec_bad    = 1'b1;
          end
        endcase
      end
      6'h08: begin
        dec_op = OP_ADD; dec_use_imm = 1'b1; dec_dest = rt; dec_we_raw = 1'b1; use_rs = 1'b1;
      end
      6'h23: begin
        dec_op = OP_LW; dec_use_imm = 1'b1; dec_dest = rt; dec_we_raw = 1'b1; use_rs = 1'b1;
      end
      6'h2B: begin
        dec_op = OP_SW; dec_use_imm = 1'b1; use_rs = 1'b1; use_rt = 1'b1;
      end
      6'h04: begin
        dec_op = OP_BEQ; use_rs = 1'b1; use_rt = 1'b1;
      end
      default: dec_bad = 1'b1;
    endcase
  end

  // r0 is never written, so an instruction targeting it neither writes nor reserves it.
  assign dec_we  = dec_we_raw && (dec_dest != '0);
  assign dec_imm = {{(XLEN-16){if_instr[15]}}, if_instr[15:0]};

  logic            ex_valid_reg, ex_use_imm_reg, ex_we_reg, err_reg;
  op_t             ex_op_reg;
  logic [XLEN-1:0] ex_opA_reg, ex_opB_reg, ex_imm_reg;
  logic [RW-1:0]   ex_dest_reg;
  logic [31:0]     ex_pc_reg;
  logic [NREG-1:0] busy_reg, busy_next;
  logic            hazard, xfer;

  // Hazard looks only at registered busy: a same-cycle writeback lands at the same edge.
  assign hazard   = (use_rs && busy_reg[rs]) || (use_rt && busy_reg[rt]);
  assign if_ready = !nrst && !flush && !hazard && (!ex_valid_reg || ex_ready);
  assign xfer     = if_valid && if_ready;

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_busy
      if (gi == 0) begin : g_zero
        assign busy_next[gi] = 1'b0;
      end else begin : g_bit
        logic set_hit, clr_hit;
        assign set_hit = xfer && dec_we && (dec_dest == RW'(gi));
        assign clr_hit = (wb_en && (wb_addr == RW'(gi))) ||
                         (flush && ex_valid_reg && ex_we_reg && (ex_dest_reg == RW'(gi)));
        // A new reservation outranks a clear of the same register.
        assign busy_next[gi] = set_hit || (busy_reg[gi] && !clr_hit);
      end
    end
  endgenerate

  always_ff @(posedge elk) begin
    if (nrst) begin
      ex_valid_reg   <= 1'b0;
      ex_op_reg      <= OP_NOP;
      ex_opA_reg     <= '0;
      ex_opB_reg     <= '0;
      ex_imm_reg     <= '0;
      ex_use_imm_reg <= 1'b0;
      ex_dest_reg    <= '0;
      ex_we_reg      <= 1'b0;
      ex_pc_reg      <= '0;
      busy_reg       <= '0;
      err_reg        <= 1'b0;
    end else begin
      busy_reg <= busy_next;
      if (flush) begin
        ex_valid_reg <= 1'b0;
      end else if (xfer) begin
        ex_valid_reg   <= 1'b1;
        ex_op_reg      <= dec_op;
        ex_opA_reg     <= rd_dataA;
        ex_opB_reg     <= rd_dataB;
        ex_imm_reg     <= dec_imm;
        ex_use_imm_reg <= dec_use_imm;
        ex_dest_reg    <= dec_dest;
        ex_we_reg      <= dec_we;
        ex_pc_reg      <= if_pc;
        if (dec_bad) err_reg <= 1'b1;
      end else if (ex_ready) begin
        ex_valid_reg <= 1'b0;
      end
    end
  end

  assign ex_valid   = ex_valid_reg;
  assign ex_op      = ex_op_reg;
  assign ex_opA     = ex_opA_reg;
  assign ex_opB     = ex_opB_reg;
  assign ex_imm     = ex_imm_reg;
  assign ex_use_imm = ex_use_imm_reg;
  assign ex_dest    = ex_dest_reg;
  assign ex_we      = ex_we_reg;
  assign ex_pc      = ex_pc_reg;
  assign err        = err_reg;
endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: a decode vector table plus hand-written
// sequences for reset, RAW stalls, back-pressure, flush and scoreboard corners.
module tb_decode_stage;
  logic        elk = 1'b0;
  logic        nrst, if_valid, if_ready, ex_valid, ex_ready, ex_use_imm, ex_we;
  logic        wb_en, flush, err;
  logic [31:0] if_instr, if_pc, rd_dataA, rd_dataB, ex_opA, ex_opB, ex_imm, ex_pc;
  logic [4:0]  rd_addrA, rd_addrB, ex_dest, wb_addr;
  logic [3:0]  ex_op;

  int checks = 0;
  int errors = 0;

  always #5 elk = ~elk;

  decode_stage #(.XLEN(32), .NREG(32)) dut (
    .elk(elk), .nrst(nrst), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .if_ready(if_ready), .rd_addrA(rd_addrA), .rd_addrB(rd_addrB),
    .rd_dataA(rd_dataA), .rd_dataB(rd_dataB), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_op(ex_op), .ex_opA(ex_opA), .ex_opB(ex_opB), .ex_imm(ex_imm),
    .ex_use_imm(ex_use_imm), .ex_dest(ex_dest), .ex_we(ex_we), .ex_pc(ex_pc),
    .wb_en(wb_en), .wb_addr(wb_addr), .flush(flush), .err(err)
  );

  typedef struct {
    logic [31:0] instr, da, db, pc;
    logic [4:0]  ea, eb;
    logic [3:0]  op;
    logic [31:0] imm;
    logic        ui;
    logic [4:0]  dest;
    logic        chk_dest;
    logic        we;
    logic        err;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge elk);
    #1;
  endtask

  task automatic do_reset();
    nrst = 1'b1; if_valid = 1'b0; flush = 1'b0; wb_en = 1'b0; wb_addr = 5'd0; ex_ready = 1'b1;
    tick(); tick();
    nrst = 1'b0;
  endtask

  // Present an instruction for one edge; expects it to be accepted.
  task automatic issue(input logic [31:0] instr, input logic [31:0] pc, input string name);
    if_instr = instr; if_pc = pc; if_valid = 1'b1;
    #1;
    chk({name, " accept"}, {31'd0, if_ready}, 32'd1);
    tick();
    if_valid = 1'b0;
  endtask

  vec_t vecs[13];

  initial begin
    vecs[0]  = '{32'h00221820, 32'd5, 32'd7, 32'h1000, 5'd1, 5'd2, 4'd1, 32'h00001820, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0};
    vecs[1]  = '{32'h00612022, 32'd9, 32'd4, 32'h1004, 5'd3, 5'd1, 4'd2, 32'h00002022, 1'b0, 5'd4, 1'b1, 1'b1, 1'b0};
    vecs[2]  = '{32'h00C72824, 32'hF0F0, 32'h0FF0, 32'h1008, 5'd6, 5'd7, 4'd3, 32'h00002824, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0};
    vecs[3]  = '{32'h012A4025, 32'h1, 32'h2, 32'h100C, 5'd9, 5'd10, 4'd4, 32'h00004025, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0};
    vecs[4]  = '{32'h018D582A, 32'hFFFFFFFF, 32'h3, 32'h1010, 5'd12, 5'd13, 4'd5, 32'h0000582A, 1'b0, 5'd11, 1'b1, 1'b1, 1'b0};
    vecs[5]  = '{32'h20208000, 32'd10, 32'h11, 32'h1014, 5'd1, 5'd0, 4'd1, 32'hFFFF8000, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{32'h20220005, 32'd20, 32'h22, 32'h1018, 5'd1, 5'd2, 4'd1, 32'h00000005, 1'b1, 5'd2, 1'b1, 1'b1, 1'b0};
    vecs[7]  = '{32'h8C25FFFC, 32'h400, 32'h33, 32'h101C, 5'd1, 5'd5, 4'd6, 32'hFFFFFFFC, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0};
    vecs[8]  = '{32'hAC250008, 32'h400, 32'hABCD, 32'h1020, 5'd1, 5'd5, 4'd7, 32'h00000008, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{32'h1022FFFF, 32'd1, 32'd1, 32'h1024, 5'd1, 5'd2, 4'd8, 32'hFFFFFFFF, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{32'hFC000000, 32'd1, 32'd2, 32'h1028, 5'd0, 5'd0, 4'd0, 32'h00000000, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{32'h00221821, 32'd1, 32'd2, 32'h102C, 5'd1, 5'd2, 4'd0, 32'h00001821, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1};
    vecs[12] = '{32'h00220020, 32'd3, 32'd4, 32'h1030, 5'd1, 5'd2, 4'd1, 32'h00000020, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0};

    nrst = 1'b1; if_valid = 1'b1; if_instr = 32'h00221820; if_pc = 32'h0;
    rd_dataA = 32'd0; rd_dataB = 32'd0; ex_ready = 1'b1; wb_en = 1'b0; wb_addr = 5'd0; flush = 1'b0;

    // Reset held two cycles with a valid instruction waiting.
    tick(); tick();
    chk("rst if_ready", {31'd0, if_ready}, 32'd0);
    chk("rst ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("rst err", {31'd0, err}, 32'd0);
    chk("rst ex_op", {28'd0, ex_op}, 32'd0);
    chk("rst ex_pc", ex_pc, 32'd0);
    if_valid = 1'b0;
    rd_dataA = 32'd0;
    nrst = 1'b0;
    if_instr = 32'h00612022;  // reads r3/r1: nothing busy after reset
    #1;
    chk("rst busy empty", {31'd0, if_ready}, 32'd1);
    $display("reset: if_ready=%b ex_valid=%b err=%b", if_ready, ex_valid, err);

    // Decode table, one fresh reset per vector.
    for (int i = 0; i < 13; i++) begin
      do_reset();
      if_instr = vecs[i].instr; rd_dataA = vecs[i].da; rd_dataB = vecs[i].db; if_pc = vecs[i].pc;
      if_valid = 1'b1;
      #1;
      chk($sformatf("v%0d rd_addrA", i), {27'd0, rd_addrA}, {27'd0, vecs[i].ea});
      chk($sformatf("v%0d rd_addrB", i), {27'd0, rd_addrB}, {27'd0, vecs[i].eb});
      chk($sformatf("v%0d if_ready", i), {31'd0, if_ready}, 32'd1);
      tick();
      if_valid = 1'b0;
      chk($sformatf("v%0d ex_valid", i), {31'd0, ex_valid}, 32'd1);
      chk($sformatf("v%0d ex_op", i), {28'd0, ex_op}, {28'd0, vecs[i].op});
      chk($sformatf("v%0d ex_opA", i), ex_opA, vecs[i].da);
      chk($sformatf("v%0d ex_opB", i), ex_opB, vecs[i].db);
      chk($sformatf("v%0d ex_imm", i), ex_imm, vecs[i].imm);
      chk($sformatf("v%0d ex_use_imm", i), {31'd0, ex_use_imm}, {31'd0, vecs[i].ui});
      chk($sformatf("v%0d ex_we", i), {31'd0, ex_we}, {31'd0, vecs[i].we});
      chk($sformatf("v%0d ex_pc", i), ex_pc, vecs[i].pc);
      chk($sformatf("v%0d err", i), {31'd0, err}, {31'd0, vecs[i].err});
      if (vecs[i].chk_dest)
        chk($sformatf("v%0d ex_dest", i), {27'd0, ex_dest}, {27'd0, vecs[i].dest});
      $display("vec %0d: instr=%h op=%0d opA=%h opB=%h imm=%h dest=%0d we=%b err=%b",
               i, vecs[i].instr, ex_op, ex_opA, ex_opB, ex_imm, ex_dest, ex_we, err);
    end

    // RAW stall: ADD r3 issued in cycle 1, SUB r4,r3,r1 waits, wb r3 in cycle 5.
    do_reset();
    rd_dataA = 32'd5; rd_dataB = 32'd7;
    issue(32'h00221820, 32'h2000, "raw add");
    if_instr = 32'h00612022; if_pc = 32'h2004; if_valid = 1'b1;
    for (int c = 2; c <= 4; c++) begin
      #1;
      chk($sformatf("raw stall c%0d", c), {31'd0, if_ready}, 32'd0);
      tick();
    end
    chk("raw add drained", {31'd0, ex_valid}, 32'd0);
    wb_en = 1'b1; wb_addr = 5'd3;
    #1;
    chk("raw no bypass c5", {31'd0, if_ready}, 32'd0);
    tick();
    wb_en = 1'b0;
    #1;
    chk("raw release c6", {31'd0, if_ready}, 32'd1);
    tick();
    if_valid = 1'b0;
    chk("raw sub op", {28'd0, ex_op}, 32'd2);
    chk("raw sub dest", {27'd0, ex_dest}, 32'd4);
    chk("raw sub pc", ex_pc, 32'h2004);
    $display("raw: sub issued op=%0d dest=%0d", ex_op, ex_dest);
    issue(32'h20208000, 32'h2008, "addi r0");
    chk("addi r0 we", {31'd0, ex_we}, 32'd0);
    chk("addi r0 imm", ex_imm, 32'hFFFF8000);
    if_instr = 32'h00000020;  // ADD r0,r0,r0 reads r0
    #1;
    chk("r0 never busy", {31'd0, if_ready}, 32'd1);

    // Back-pressure: ADD r6 held for 3 cycles while OR r7 waits.
    do_reset();
    rd_dataA = 32'hA; rd_dataB = 32'hB;
    issue(32'h00223020, 32'h3000, "bp add");
    ex_ready = 1'b0;
    if_instr = 32'h00223825; if_pc = 32'h3004; if_valid = 1'b1;
    rd_dataA = 32'h55; rd_dataB = 32'h66;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("bp if_ready c%0d", c), {31'd0, if_ready}, 32'd0);
      tick();
      chk($sformatf("bp valid c%0d", c), {31'd0, ex_valid}, 32'd1);
      chk($sformatf("bp dest c%0d", c), {27'd0, ex_dest}, 32'd6);
      chk($sformatf("bp opA c%0d", c), ex_opA, 32'hA);
      chk($sformatf("bp pc c%0d", c), ex_pc, 32'h3000);
    end
    ex_ready = 1'b1;
    #1;
    chk("bp resume ready", {31'd0, if_ready}, 32'd1);
    tick();
    if_valid = 1'b0;
    chk("bp or op", {28'd0, ex_op}, 32'd4);
    chk("bp or dest", {27'd0, ex_dest}, 32'd7);
    chk("bp or opA", ex_opA, 32'h55);
    $display("backpressure: or loaded op=%0d dest=%0d", ex_op, ex_dest);

    // Flush: LW r5 held in ID/EX, flushed; dependent ADD r8,r5,r5 then issues without wb.
    do_reset();
    issue(32'h8C250000, 32'h4000, "flush lw");
    ex_ready = 1'b0;
    if_instr = 32'h00A54020; if_pc = 32'h4004; if_valid = 1'b1;
    #1;
    chk("flush pre stall", {31'd0, if_ready}, 32'd0);
    tick();
    flush = 1'b1;
    #1;
    chk("flush blocks issue", {31'd0, if_ready}, 32'd0);
    tick();
    flush = 1'b0;
    chk("flush valid", {31'd0, ex_valid}, 32'd0);
    #1;
    chk("flush busy5 cleared", {31'd0, if_ready}, 32'd1);
    tick();
    if_valid = 1'b0;
    chk("flush dep valid", {31'd0, ex_valid}, 32'd1);
    chk("flush dep dest", {27'd0, ex_dest}, 32'd8);
    $display("flush: dependent add issued dest=%0d", ex_dest);

    // Sticky err, cleared only by reset.
    do_reset();
    issue(32'hFC000000, 32'h5000, "bad op");
    chk("err set", {31'd0, err}, 32'd1);
    chk("bad op we", {31'd0, ex_we}, 32'd0);
    issue(32'h00221820, 32'h5004, "after bad");
    tick();
    chk("err sticky", {31'd0, err}, 32'd1);
    do_reset();
    chk("err cleared", {31'd0, err}, 32'd0);
    $display("err: sticky until reset");

    // Set and clear of busy[6] in the same cycle: set wins.
    issue_with_wb();
    if_instr = 32'h00C63825;  // OR r7,r6,r6
    #1;
    chk("set wins busy6", {31'd0, if_ready}, 32'd0);
    tick();
    chk("busy6 holds", {31'd0, if_ready}, 32'd0);
    wb_en = 1'b1; wb_addr = 5'd6;
    tick();
    wb_en = 1'b0;
    #1;
    chk("busy6 retired", {31'd0, if_ready}, 32'd1);
    $display("scoreboard: same-cycle set/clear of r6 kept busy");

    // Reset mid-stall drops the held instruction and the scoreboard.
    do_reset();
    issue(32'h00221820, 32'h6000, "mid add");
    ex_ready = 1'b0;
    nrst = 1'b1;
    #1;
    chk("mid rst if_ready", {31'd0, if_ready}, 32'd0);
    tick();
    nrst = 1'b0; ex_ready = 1'b1;
    chk("mid rst valid", {31'd0, ex_valid}, 32'd0);
    chk("mid rst op", {28'd0, ex_op}, 32'd0);
    if_instr = 32'h00612022;
    #1;
    chk("mid rst busy3", {31'd0, if_ready}, 32'd1);
    $display("reset mid-stall: held instruction dropped");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Issues ADD r6,r1,r2 while writeback retires r6 in the same cycle.
  task automatic issue_with_wb();
    wb_en = 1'b1; wb_addr = 5'd6;
    issue(32'h00223020, 32'h5100, "set/clr add");
    wb_en = 1'b0;
  endtask
endmodule
